elastic_stage_reg: RTL and testbench
====================================

Name: elastic_stage_reg

Overview:
- Parametrised successor of the fixed EX/MEM latch: a pipeline stage register with a valid/ready handshake, stall absorption and flush.
- A 2-entry skid buffer allows full throughput while in_ready stays a registered signal.
- Control and data fields have independent widths. Invalid slots present a programmable bubble control word, so downstream write enables are never asserted spuriously.
- Used between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, width of the data payload (e.g. ALUout + rt_data).
- CTRL_W, 8, width of the control payload (e.g. Mem_wr, MemtoReg, RegWr, Write_register).
- CTRL_BUBBLE, 0, value driven on out_ctrl whenever out_valid=0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
- in_ctrl  input  CTRL_W  upstream control payload.
- in_data  input  DATA_W  upstream data payload.
- out_valid  output  1  entry present on outputs.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  head control; equals CTRL_BUBBLE when out_valid=0.
- out_data  output  DATA_W  head data; value undefined-but-stable when out_valid=0 (held).
- level  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage:
  - main register (head, drives outputs) and skid register, each holding valid/ctrl/data.
  - level = main_v + skid_v.
  - skid_v=1 implies main_v=1.
- Transfer definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both evaluated in the same cycle and applied at the rising edge.
- Reset:
  - Applies while reset=0, sampled at the clk edge; it has priority over flush and every other input.
  - Clears main_v and skid_v, sets ctrl regs to CTRL_BUBBLE and data regs to 0, and forces in_ready=0.
  - First edge with reset=1 sets in_ready=1.
  - Reset mid-operation loses all entries; no partial transfer completes.
- in_ready: registered, next value = !(next skid_v), i.e. low only when level will be 2.
- Latency: a push into an empty stage appears at out_valid=1 in the next cycle (1-cycle latency). Throughput is 1 entry/cycle with out_ready=1.
- State transitions (level, push, pop):
  - 0, push, pop not possible: main <= in; level becomes 1.
  - 1, push, no pop: skid <= in; level becomes 2; in_ready falls next cycle.
  - 1, push, pop: main <= in; level stays 1.
  - 1, no push, pop: main_v <= 0; level becomes 0.
  - 2, pop: main <= skid, skid_v <= 0; level becomes 1; in_ready rises next cycle. Push is impossible at level 2 since in_ready=0.
  - No push and no pop: all registers hold. A stall holds out_ctrl/out_data stable, so no field changes while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; skid contents always precede any newer input.
- Flush:
  - flush=1 at an edge (with reset=1) clears main_v and skid_v and sets ctrl regs to CTRL_BUBBLE.
  - Any push in that cycle is discarded; upstream still treats it as handed off.
  - A pop in that cycle is considered complete by downstream.
  - in_ready=1 in the following cycle.
  - Data regs hold their values.
- Bubble masking: out_ctrl = out_valid ? main_ctrl : CTRL_BUBBLE. This is a combinational mux on registered state.
- No internal counters wrap; level never exceeds 2. Assertion: push when level=2 is a design error and must not occur, since in_ready=0 forbids it.

Test Plan:
1. Reset/bubble: hold reset=0 for 3 cycles with in_valid=1, CTRL_BUBBLE=8'h00 -> out_valid=0, out_ctrl=8'h00, level=0, in_ready=0; first cycle after release in_ready=1 and nothing was captured.
2. Streaming: out_ready=1, push ctrl 8'h11..8'h14 with data 1..4 on consecutive cycles -> each appears on out one cycle later in order, level stays 1, in_ready stays 1.
3. Stall/skid: level=1 holding A=5, drop out_ready, push B=6 -> level=2, in_ready=0 next cycle, out_data holds 5 throughout. Raise out_ready -> 5 then 6 pop on consecutive cycles, in_ready=1 one cycle after the first pop.
4. Flush with simultaneous push: level=2 (entries 7, 8), assert flush plus push 9 in the same cycle -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, level=0, in_ready=1, and 9 never appears.
5. Simultaneous push/pop at level 1: entry 10 held, push 11 with out_ready=1 -> 10 pops, 11 at head next cycle, level=1.
6. Reset mid-stall: level=2, assert reset=0 for one edge with flush=1 and in_valid=1 -> level=0, in_ready=0, out_ctrl=CTRL_BUBBLE; after release, no stale entry ever reappears.

Source files
------------

// File: rtl/elastic_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// The stage is flushable, in_ready is registered, and empty slots present a bubble control word.
module elastic_stage_reg #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
);

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic              main_v_n, skid_v_n;
    logic [CTRL_W-1:0] main_ctrl_n, skid_ctrl_n;
    logic [DATA_W-1:0] main_data_n, skid_data_n;

    logic push, pop;

    assign push = in_valid & in_ready;
    assign pop  = main_v & out_ready;

    always_comb begin
        main_v_n    = main_v;
        skid_v_n    = skid_v;
        main_ctrl_n = main_ctrl;
        skid_ctrl_n = skid_ctrl;
        main_data_n = main_data;
        skid_data_n = skid_data;
        if (flush) begin
            main_v_n    = 1'b0;
            skid_v_n    = 1'b0;
            main_ctrl_n = CTRL_BUBBLE;
            skid_ctrl_n = CTRL_BUBBLE;
        end else if (pop && skid_v) begin
            // Skid always drains into main before any newer input, keeping FIFO order.
            main_ctrl_n = skid_ctrl;
            main_data_n = skid_data;
            skid_v_n    = 1'b0;
        end else if (pop && push) begin
            main_ctrl_n = in_ctrl;
            main_data_n = in_data;
        end else if (pop) begin
            main_v_n    = 1'b0;
        end else if (push && !main_v) begin
            main_v_n    = 1'b1;
            main_ctrl_n = in_ctrl;
            main_data_n = in_data;
        end else if (push) begin
            skid_v_n    = 1'b1;
            skid_ctrl_n = in_ctrl;
            skid_data_n = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            main_ctrl <= CTRL_BUBBLE;
            skid_ctrl <= CTRL_BUBBLE;
            main_data <= '0;
            skid_data <= '0;
            in_ready  <= 1'b0;
        end else begin
            main_v    <= main_v_n;
            skid_v    <= skid_v_n;
            main_ctrl <= main_ctrl_n;
            skid_ctrl <= skid_ctrl_n;
            main_data <= main_data_n;
            skid_data <= skid_data_n;
            in_ready  <= !skid_v_n;
        end
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_v ? main_ctrl : CTRL_BUBBLE;
    assign out_data  = main_data;
    assign level     = {1'b0, main_v} + {1'b0, skid_v};

    no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(push && skid_v));

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Self-checking bench for elastic_stage_reg: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_elastic_stage_reg;

    localparam logic [7:0] BUB = 8'h00;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [63:0] in_data, out_data;
    logic [1:0]  level;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] d;
    } entry_t;

    entry_t q[$];
    bit     rdy_m = 1'b0;

    elastic_stage_reg #(
        .DATA_W(64),
        .CTRL_W(8),
        .CTRL_BUBBLE(BUB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs, advances to the next edge and updates the reference queue.
    task automatic cycle(input logic iv, input logic [7:0] c, input logic [63:0] d,
                         input logic ordy, input logic fl, input logic rst);
        bit push_m, pop_m;
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; reset = rst;
        push_m = iv && rdy_m;
        pop_m  = (q.size() != 0) && ordy;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            rdy_m = 1'b0;
        end else if (fl) begin
            q.delete();
            rdy_m = 1'b1;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back('{c: c, d: d});
            rdy_m = (q.size() < 2);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hAA, 64'hDEAD, 1'b1, 1'b0, 1'b0);
            checks++;
            if ({out_valid, level, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b0, BUB}) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got v/lvl/rdy/ctrl=%h want %h", i,
                         {out_valid, level, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b0, BUB});
            end
        end
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, level, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b1, BUB}) begin
            errors++;
            $display("FAIL reset_release: got v/lvl/rdy/ctrl=%h want %h",
                     {out_valid, level, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b1, BUB});
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h11 + 8'(i), 64'(i + 1), 1'b1, 1'b0, 1'b1);
            checks++;
            if ({out_valid, level, in_ready, out_ctrl, out_data} !==
                {1'b1, 2'd1, 1'b1, 8'h11 + 8'(i), 64'(i + 1)}) begin
                errors++;
                $display("FAIL stream[%0d]: got v/lvl/rdy/ctrl/data=%h want %h", i,
                         {out_valid, level, in_ready, out_ctrl, out_data},
                         {1'b1, 2'd1, 1'b1, 8'h11 + 8'(i), 64'(i + 1)});
            end
        end
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, level, out_ctrl} !== {1'b0, 2'd0, BUB}) begin
            errors++;
            $display("FAIL stream_drain: got %h want %h", {out_valid, level, out_ctrl}, {1'b0, 2'd0, BUB});
        end
    endtask

    task automatic test_stall_skid();
        logic [11:0] exp [4];
        logic [63:0] expd [4];
        cycle(1'b1, 8'h25, 64'd5, 1'b0, 1'b0, 1'b1);
        exp[0] = {1'b1, 2'd2, 1'b0, 8'h25}; expd[0] = 64'd5;
        cycle(1'b1, 8'h26, 64'd6, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, level, in_ready, out_ctrl} !== exp[0] || out_data !== expd[0]) begin
            errors++;
            $display("FAIL skid_fill: got %h/%0d want %h/%0d", {out_valid, level, in_ready, out_ctrl},
                     out_data, exp[0], expd[0]);
        end
        exp[1] = exp[0]; expd[1] = 64'd5;
        exp[2] = {1'b1, 2'd1, 1'b1, 8'h26}; expd[2] = 64'd6;
        exp[3] = {1'b0, 2'd0, 1'b1, BUB};  expd[3] = 64'd6;
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 8'h00, 64'h0, (i != 1), 1'b0, 1'b1);
            checks++;
            if ({out_valid, level, in_ready, out_ctrl} !== exp[i] || out_data !== expd[i]) begin
                errors++;
                $display("FAIL skid_step[%0d]: got %h/%0d want %h/%0d", i,
                         {out_valid, level, in_ready, out_ctrl}, out_data, exp[i], expd[i]);
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 8'h37, 64'd7, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h38, 64'd8, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h39, 64'd9, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, level, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b1, BUB}) begin
            errors++;
            $display("FAIL flush: got v/lvl/rdy/ctrl=%h want %h",
                     {out_valid, level, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b1, BUB});
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({out_valid, level, out_ctrl} !== {1'b0, 2'd0, BUB}) begin
                errors++;
                $display("FAIL flush_after[%0d]: got %h want %h", i, {out_valid, level, out_ctrl},
                         {1'b0, 2'd0, BUB});
            end
        end
    endtask

    task automatic test_push_pop();
        cycle(1'b1, 8'h4A, 64'd10, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h4B, 64'd11, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, level, in_ready, out_ctrl, out_data} !== {1'b1, 2'd1, 1'b1, 8'h4B, 64'd11}) begin
            errors++;
            $display("FAIL push_pop: got %h want %h", {out_valid, level, in_ready, out_ctrl, out_data},
                     {1'b1, 2'd1, 1'b1, 8'h4B, 64'd11});
        end
        cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8'h5C, 64'd12, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h5D, 64'd13, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h5E, 64'd14, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({out_valid, level, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b0, BUB}) begin
            errors++;
            $display("FAIL reset_mid: got v/lvl/rdy/ctrl=%h want %h",
                     {out_valid, level, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b0, BUB});
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({out_valid, level, in_ready, out_ctrl} !== {1'b0, 2'd0, 1'b1, BUB}) begin
                errors++;
                $display("FAIL reset_mid_after[%0d]: got %h want %h", i,
                         {out_valid, level, in_ready, out_ctrl}, {1'b0, 2'd0, 1'b1, BUB});
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] exp;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 59) != 0);
            exp = {q.size() != 0, 2'(q.size()), rdy_m, (q.size() != 0) ? q[0].c : BUB};
            checks++;
            if ({out_valid, level, in_ready, out_ctrl} !== exp) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got v/lvl/rdy/ctrl=%h want %h", i,
                         {out_valid, level, in_ready, out_ctrl}, exp);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0].d) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, q[0].d);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
